// File: rtl/stopwatch_lap_if.sv
// Key inputs and display/status outputs of the stopwatch_lap core.
// master: key driver / display consumer; slave: the stopwatch core.
interface stopwatch_lap_if #(
   parameter int unsigned LAP_DEPTH = 4
);
   localparam int unsigned IDX_W = (LAP_DEPTH > 1) ? $clog2(LAP_DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(LAP_DEPTH + 1);

   logic             key_start_pause;
   logic             key_lap;
   logic             key_clear;
   logic [23:0]      disp_bcd;
   logic             running;
   logic             recall_active;
   logic [IDX_W-1:0] recall_idx;
   logic [CNT_W-1:0] lap_count;
   logic             lap_full;
   logic             overflow;

   modport master (
      output key_start_pause, key_lap, key_clear,
      input  disp_bcd, running, recall_active, recall_idx, lap_count, lap_full, overflow
   );

   modport slave (
      input  key_start_pause, key_lap, key_clear,
      output disp_bcd, running, recall_active, recall_idx, lap_count, lap_full, overflow
   );
endinterface

// File: rtl/stopwatch_lap.sv
// Stopwatch core: key debounce, MM:SS.CC BCD counter, lap buffer with recall.
// Optional macro STOPWATCH_OVF_STOP_EN: freeze at 59:59.99 and flag overflow
// instead of wrapping to 00:00.00.
module stopwatch_lap #(
   parameter int unsigned TICK_DIV        = 500000,
   parameter int unsigned DEBOUNCE_CYCLES = 1000000,
   parameter int unsigned LAP_DEPTH       = 4
) (
   input logic            clk,
   input logic            reset,
   stopwatch_lap_if.slave sw
);
   localparam int unsigned TICK_W = $clog2(TICK_DIV);
   localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int unsigned IDX_W  = (LAP_DEPTH > 1) ? $clog2(LAP_DEPTH) : 1;
   localparam int unsigned CNT_W  = $clog2(LAP_DEPTH + 1);
   localparam int unsigned NKEY   = 3;
   localparam int unsigned K_CLR  = 0;
   localparam int unsigned K_START = 1;
   localparam int unsigned K_LAP  = 2;
`ifdef STOPWATCH_OVF_STOP_EN
   localparam logic [23:0] TIME_MAX = 24'h595999;
`endif

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_RECALL} state_e;

   state_e           state_q, state_d;
   logic             ret_pause_q, ret_pause_d;
   logic [TICK_W-1:0] tick_q, tick_d;
   logic [23:0]      time_q, time_d;
   logic [23:0]      lap_q [LAP_DEPTH];
   logic [23:0]      lap_d [LAP_DEPTH];
   logic [CNT_W-1:0] lap_cnt_q, lap_cnt_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             ovf_q, ovf_d;
   logic [23:0]      disp_q, disp_d;
   logic             running_q, running_d;
   logic             recall_q, recall_d;
   logic             lap_full_q, lap_full_d;
   logic [DB_W-1:0]  db_q [NKEY];
   logic [DB_W-1:0]  db_d [NKEY];

   logic [NKEY-1:0]  key_n_c;
   logic [NKEY-1:0]  press_c;
   logic             clr_ev, st_ev, lap_ev;
   logic             tick_c, lap_full_c, clear_all, limit_hit;
   logic [23:0]      lap_sel;

   assign key_n_c = {sw.key_lap, sw.key_start_pause, sw.key_clear};

   // BCD increment with per-digit limits; wraps 59:59.99 to 00:00.00
   function automatic logic [23:0] bcd_inc(input logic [23:0] t);
      logic [23:0] r;
      logic        carry;
      logic [3:0]  lim;
      r     = t;
      carry = 1'b1;
      for (int i = 0; i < 6; i++) begin
         lim = (i == 3 || i == 5) ? 4'd5 : 4'd9;
         if (carry) begin
            if (r[4*i +: 4] == lim) begin
               r[4*i +: 4] = 4'd0;
            end else begin
               r[4*i +: 4] = r[4*i +: 4] + 4'd1;
               carry       = 1'b0;
            end
         end
      end
      return r;
   endfunction

   // Debounce: count consecutive low samples, pulse once on reaching the limit
   always_comb begin
      press_c = '0;
      for (int k = 0; k < int'(NKEY); k++) begin
         db_d[k] = db_q[k];
         if (key_n_c[k]) begin
            db_d[k] = '0;
         end else if (db_q[k] != DB_W'(DEBOUNCE_CYCLES)) begin
            db_d[k]    = db_q[k] + DB_W'(1);
            press_c[k] = (db_q[k] == DB_W'(DEBOUNCE_CYCLES - 1));
         end
      end
   end

   // Next-state, time, lap buffer and output computation
   always_comb begin
      state_d     = state_q;
      ret_pause_d = ret_pause_q;
      tick_d      = tick_q;
      time_d      = time_q;
      lap_d       = lap_q;
      lap_cnt_d   = lap_cnt_q;
      idx_d       = idx_q;
      ovf_d       = ovf_q;
      clear_all   = 1'b0;
      limit_hit   = 1'b0;

      clr_ev = press_c[K_CLR];
      st_ev  = press_c[K_START] & ~press_c[K_CLR] & ~ovf_q;
      lap_ev = press_c[K_LAP] & ~press_c[K_START] & ~press_c[K_CLR];

      tick_c     = (state_q == S_RUN) && (tick_q == TICK_W'(TICK_DIV - 1));
      lap_full_c = (lap_cnt_q == CNT_W'(LAP_DEPTH));

      if (state_q == S_RUN) begin
         tick_d = tick_c ? '0 : tick_q + TICK_W'(1);
      end

      if (tick_c) begin
`ifdef STOPWATCH_OVF_STOP_EN
         if (time_q == TIME_MAX) begin
            limit_hit = 1'b1;
            ovf_d     = 1'b1;
         end else begin
            time_d = bcd_inc(time_q);
         end
`else
         time_d = bcd_inc(time_q);
`endif
      end

      case (state_q)
         S_IDLE: begin
            if (clr_ev) begin
               clear_all = 1'b1;
            end else if (st_ev) begin
               state_d = S_RUN;
            end else if (lap_ev && lap_cnt_q != '0) begin
               state_d     = S_RECALL;
               idx_d       = '0;
               ret_pause_d = 1'b0;
            end
         end
         S_RUN: begin
            if (st_ev) begin
               state_d = S_PAUSE;
            end else if (lap_ev && !lap_full_c) begin
               // capture the pre-tick time into the next free slot
               for (int i = 0; i < int'(LAP_DEPTH); i++) begin
                  if (lap_cnt_q == CNT_W'(i)) lap_d[i] = time_q;
               end
               lap_cnt_d = lap_cnt_q + CNT_W'(1);
            end
         end
         S_PAUSE: begin
            if (clr_ev) begin
               clear_all = 1'b1;
               state_d   = S_IDLE;
            end else if (st_ev) begin
               state_d = S_RUN;
            end else if (lap_ev && lap_cnt_q != '0) begin
               state_d     = S_RECALL;
               idx_d       = '0;
               ret_pause_d = 1'b1;
            end
         end
         S_RECALL: begin
            if (clr_ev) begin
               clear_all = 1'b1;
               state_d   = S_IDLE;
            end else if (st_ev) begin
               state_d = S_RUN;
               idx_d   = '0;
            end else if (lap_ev) begin
               if (CNT_W'(idx_q) + CNT_W'(1) == lap_cnt_q) begin
                  state_d = ret_pause_q ? S_PAUSE : S_IDLE;
                  idx_d   = '0;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (limit_hit) state_d = S_PAUSE;

      if (clear_all) begin
         time_d    = '0;
         tick_d    = '0;
         lap_cnt_d = '0;
         idx_d     = '0;
         ovf_d     = 1'b0;
      end

      lap_sel = '0;
      for (int i = 0; i < int'(LAP_DEPTH); i++) begin
         if (idx_q == IDX_W'(i)) lap_sel = lap_q[i];
      end

      disp_d     = (state_q == S_RECALL) ? lap_sel : time_q;
      running_d  = (state_d == S_RUN);
      recall_d   = (state_d == S_RECALL);
      lap_full_d = (lap_cnt_d == CNT_W'(LAP_DEPTH));
   end

   // State and datapath registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         ret_pause_q <= 1'b0;
         tick_q      <= '0;
         time_q      <= '0;
         lap_cnt_q   <= '0;
         idx_q       <= '0;
         ovf_q       <= 1'b0;
         disp_q      <= '0;
         running_q   <= 1'b0;
         recall_q    <= 1'b0;
         lap_full_q  <= 1'b0;
         for (int i = 0; i < int'(LAP_DEPTH); i++) lap_q[i] <= '0;
         for (int k = 0; k < int'(NKEY); k++) db_q[k] <= '0;
      end else begin
         state_q     <= state_d;
         ret_pause_q <= ret_pause_d;
         tick_q      <= tick_d;
         time_q      <= time_d;
         lap_cnt_q   <= lap_cnt_d;
         idx_q       <= idx_d;
         ovf_q       <= ovf_d;
         disp_q      <= disp_d;
         running_q   <= running_d;
         recall_q    <= recall_d;
         lap_full_q  <= lap_full_d;
         for (int i = 0; i < int'(LAP_DEPTH); i++) lap_q[i] <= lap_d[i];
         for (int k = 0; k < int'(NKEY); k++) db_q[k] <= db_d[k];
      end
   end

   assign sw.disp_bcd      = disp_q;
   assign sw.running       = running_q;
   assign sw.recall_active = recall_q;
   assign sw.recall_idx    = idx_q;
   assign sw.lap_count     = lap_cnt_q;
   assign sw.lap_full      = lap_full_q;
   assign sw.overflow      = ovf_q;
endmodule

// File: tb/tb_stopwatch_lap.sv
// Directed bench for stopwatch_lap (TICK_DIV=4, DEBOUNCE_CYCLES=3, LAP_DEPTH=2).
module tb_stopwatch_lap;
   localparam int unsigned TICK_DIV        = 4;
   localparam int unsigned DEBOUNCE_CYCLES = 3;
   localparam int unsigned LAP_DEPTH       = 2;
   localparam int K_CLR = 0, K_START = 1, K_LAP = 2;

   logic clk;
   logic reset;
   int   n_checks = 0;
   int   n_fail   = 0;

   stopwatch_lap_if #(.LAP_DEPTH(LAP_DEPTH)) sw_if ();

   stopwatch_lap #(
      .TICK_DIV(TICK_DIV),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .LAP_DEPTH(LAP_DEPTH)
   ) dut (
      .clk(clk),
      .reset(reset),
      .sw(sw_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic set_key(input int k, input logic v);
      case (k)
         K_CLR:   sw_if.key_clear       = v;
         K_START: sw_if.key_start_pause = v;
         default: sw_if.key_lap         = v;
      endcase
   endtask

   // Pulse fires on the 3rd low edge; returns one negedge after the release edge
   task automatic press(input int k);
      set_key(k, 1'b0);
      repeat (DEBOUNCE_CYCLES) @(negedge clk);
      set_key(k, 1'b1);
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      reset                 = 1'b1;
      sw_if.key_start_pause = 1'b1;
      sw_if.key_lap         = 1'b1;
      sw_if.key_clear       = 1'b1;
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      do_reset();
      check_eq("rst_disp",    32'(sw_if.disp_bcd), 32'h0);
      check_eq("rst_running", 32'(sw_if.running), 32'h0);
      check_eq("rst_recall",  32'(sw_if.recall_active), 32'h0);
      check_eq("rst_idx",     32'(sw_if.recall_idx), 32'h0);
      check_eq("rst_lapcnt",  32'(sw_if.lap_count), 32'h0);
      check_eq("rst_lapfull", 32'(sw_if.lap_full), 32'h0);
      check_eq("rst_ovf",     32'(sw_if.overflow), 32'h0);

      // Debounce: short glitch ignored, long hold gives a single pulse
      sw_if.key_start_pause = 1'b0;
      idle(2);
      sw_if.key_start_pause = 1'b1;
      idle(3);
      check_eq("db_short", 32'(sw_if.running), 32'h0);
      sw_if.key_start_pause = 1'b0;
      idle(2);
      check_eq("db_2low", 32'(sw_if.running), 32'h0);
      idle(1);
      check_eq("db_3low", 32'(sw_if.running), 32'h1);
      idle(7);
      check_eq("db_hold10", 32'(sw_if.running), 32'h1);
      sw_if.key_start_pause = 1'b1;

      // Lap in IDLE with no laps stored does not enter recall
      do_reset();
      press(K_LAP);
      check_eq("idle_lap_empty", 32'(sw_if.recall_active), 32'h0);

      // Count and carry: start edge E, checkpoints at E+401, E+23997, pause at E+24003
      do_reset();
      press(K_START);
      idle(400);
      check_eq("cnt_1s", 32'(sw_if.disp_bcd), 32'h000100);
      idle(23596);
      check_eq("cnt_5999", 32'(sw_if.disp_bcd), 32'h005999);
      idle(3);
      press(K_START);
      check_eq("carry_min", 32'(sw_if.disp_bcd), 32'h010000);
      check_eq("carry_paused", 32'(sw_if.running), 32'h0);

      // Pause/resume: 6 run edges leave tick_cnt=2, next tick 2 edges after resume
      do_reset();
      press(K_START);
      idle(2);
      press(K_START);
      idle(20);
      check_eq("pause_hold", 32'(sw_if.disp_bcd), 32'h000001);
      check_eq("pause_run", 32'(sw_if.running), 32'h0);
      press(K_START);
      check_eq("resume_b1", 32'(sw_if.disp_bcd), 32'h000001);
      idle(1);
      check_eq("resume_b2", 32'(sw_if.disp_bcd), 32'h000001);
      idle(1);
      check_eq("resume_tick", 32'(sw_if.disp_bcd), 32'h000002);

      // Laps: captures at cs=05 and cs=09 (same edge as tick), third dropped
      do_reset();
      press(K_START);
      idle(18);
      press(K_LAP);
      idle(14);
      press(K_LAP);
      check_eq("lap_cnt2", 32'(sw_if.lap_count), 32'h2);
      check_eq("lap_full", 32'(sw_if.lap_full), 32'h1);
      idle(6);
      press(K_LAP);
      check_eq("lap_drop", 32'(sw_if.lap_count), 32'h2);
      press(K_START);
      check_eq("lap_paused", 32'(sw_if.running), 32'h0);
      check_eq("lap_live", 32'(sw_if.disp_bcd), 32'h000013);
      press(K_LAP);
      check_eq("rc0_active", 32'(sw_if.recall_active), 32'h1);
      check_eq("rc0_idx", 32'(sw_if.recall_idx), 32'h0);
      check_eq("rc0_disp", 32'(sw_if.disp_bcd), 32'h000005);
      press(K_LAP);
      check_eq("rc1_idx", 32'(sw_if.recall_idx), 32'h1);
      check_eq("rc1_disp", 32'(sw_if.disp_bcd), 32'h000009);
      press(K_LAP);
      check_eq("rc_exit", 32'(sw_if.recall_active), 32'h0);
      check_eq("rc_exit_idx", 32'(sw_if.recall_idx), 32'h0);
      check_eq("rc_exit_disp", 32'(sw_if.disp_bcd), 32'h000013);
      check_eq("rc_exit_run", 32'(sw_if.running), 32'h0);

      // Priority: clear beats start in PAUSE
      sw_if.key_clear       = 1'b0;
      sw_if.key_start_pause = 1'b0;
      idle(DEBOUNCE_CYCLES);
      sw_if.key_clear       = 1'b1;
      sw_if.key_start_pause = 1'b1;
      idle(2);
      check_eq("prio_run", 32'(sw_if.running), 32'h0);
      check_eq("prio_disp", 32'(sw_if.disp_bcd), 32'h0);
      check_eq("prio_laps", 32'(sw_if.lap_count), 32'h0);
      check_eq("prio_full", 32'(sw_if.lap_full), 32'h0);

      // Clear while running is ignored
      do_reset();
      press(K_START);
      idle(20);
      press(K_CLR);
      check_eq("run_clr_run", 32'(sw_if.running), 32'h1);
      check_eq("run_clr_disp", 32'(sw_if.disp_bcd), 32'h000006);

      // Limit: preload 59:59.95 while idle, fifth tick hits the limit at E+20
      do_reset();
      force dut.time_q = 24'h595995;
      @(negedge clk);
      release dut.time_q;
      press(K_START);
      idle(21);
`ifdef STOPWATCH_OVF_STOP_EN
      check_eq("lim_disp", 32'(sw_if.disp_bcd), 32'h595999);
      check_eq("lim_ovf", 32'(sw_if.overflow), 32'h1);
      check_eq("lim_run", 32'(sw_if.running), 32'h0);
      press(K_START);
      check_eq("lim_start_ign", 32'(sw_if.running), 32'h0);
      press(K_CLR);
      idle(1);
      check_eq("lim_clr_ovf", 32'(sw_if.overflow), 32'h0);
      check_eq("lim_clr_disp", 32'(sw_if.disp_bcd), 32'h0);
`else
      check_eq("wrap_disp", 32'(sw_if.disp_bcd), 32'h000000);
      check_eq("wrap_ovf", 32'(sw_if.overflow), 32'h0);
      check_eq("wrap_run", 32'(sw_if.running), 32'h1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
